uid_scan_controller: RTL and testbench
======================================

UID_SCAN_CONTROLLER -- requirements
Module: uid_scan_controller

Interface
REQ-001 Parameter DATA_W, default 16, is the width of each user-ID word.
REQ-002 Parameter DEPTH, default 8, is the number of ROM entries scanned (2..256, need not be a power of two).
REQ-003 Parameter ADDR_W, default 3, is the ROM address width; it SHALL be at least clog2(DEPTH).
REQ-004 Parameter VACANT, default all-ones of DATA_W, is the word marking an empty slot.
REQ-005 Port list: clk in 1, the single clock, rising edge; rst in 1, asynchronous active-high reset.
REQ-006 Port list: start in 1, request a scan; mode in 1, 0 stops at first match and 1 scans all entries; key in DATA_W, the ID to search for.
REQ-007 Port list: rom_addr out ADDR_W, the address to the synchronous user-ID ROM; rom_q in DATA_W, the ROM data, valid one cycle after rom_addr.
REQ-008 Port list: busy out 1, scan in progress; done out 1, one-cycle completion pulse; found out 1, at least one match.
REQ-009 Port list: match_idx out ADDR_W, lowest matching index; match_count out clog2(DEPTH+1), number of matches.

Function
REQ-010 The FSM SHALL have the states IDLE, SCAN, DRAIN and FINISH.
REQ-011 In IDLE, start=1 at a rising edge SHALL latch key and mode, clear found, match_idx and match_count, set busy and enter SCAN, with rom_addr=0 in the next cycle (t1).
REQ-012 In SCAN, rom_addr SHALL increment by 1 per cycle; entry k is addressed at cycle t(k+1) and compared at cycle t(k+2).
REQ-013 Compare rule: an entry matches only if rom_q equals the latched key and rom_q does not equal VACANT.
REQ-014 When rom_addr=DEPTH-1 is issued, the FSM SHALL enter DRAIN; rom_addr SHALL NOT exceed DEPTH-1.
REQ-015 In DRAIN, the FSM SHALL compare the last entry and then enter FINISH.
REQ-016 In FINISH, done=1 for exactly one cycle, busy=0, and the FSM SHALL return to IDLE.
REQ-017 Full scan (mode=1): done SHALL occur at cycle t(DEPTH+2).
REQ-018 mode=0: the first match at entry k SHALL abort the scan, discard the in-flight read and give done at t(k+3).
REQ-019 On each match, match_count SHALL increment, saturating at DEPTH; match_idx and found SHALL be set on the first match only.
REQ-020 found, match_idx and match_count SHALL hold their values after done until the next accepted start.
REQ-021 start while busy=1 or in FINISH SHALL be ignored; changes to key or mode during a scan SHALL have no effect.
REQ-022 If no entry matches, the result at done SHALL be found=0, match_idx=0, match_count=0.
REQ-023 A key equal to VACANT SHALL never match.
REQ-024 start held high continuously SHALL launch a new scan in the cycle after each FINISH.

Reset
REQ-025 rst=1 SHALL immediately force IDLE with rom_addr=0, busy=0, done=0, found=0, match_idx=0 and match_count=0, regardless of clk.
REQ-026 Reset asserted mid-scan SHALL abandon the scan with no done pulse; after release, the block SHALL accept start normally.

Structure
REQ-027 The FSM state enum and the default VACANT constant SHALL reside in the shared package uid_pkg.
REQ-028 No sub-module: one FSM, one address counter and one compare/accumulate stage; the ROM SHALL remain external, with the existing user-ID ROM as the bench model.

Verification
Common setup for all scenarios: DEPTH=8, DATA_W=16, ROM contents {0:1234, 1:0001, 2:0002, 3:BEEF, 4:0004, 5:FFFF, 6:BEEF, 7:0007}.
REQ-029 key=BEEF, mode=1, start at t0 -> done at t10, found=1, match_idx=3, match_count=2.
REQ-030 key=BEEF, mode=0 -> done at t6, found=1, match_idx=3, match_count=1, rom_addr never above 4.
REQ-031 key=FFFF, mode=1 -> done at t10, found=0, match_count=0; key=7777 -> same result.
REQ-032 Second start pulsed at t4 during a scan is ignored (a single done); rst pulsed at t5 mid-scan -> all outputs 0 asynchronously, no done, and a following scan is correct.
REQ-033 DEPTH=5, ADDR_W=3, key=0004, mode=1 -> rom_addr sequence 0..4 only, done at t7, match_idx=4, match_count=1.

Source files
------------

// File: rtl/uid_pkg.sv
// uid_pkg: shared FSM states and constants for the user-ID scanner
package uid_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} scan_state_t;
  localparam logic [255:0] VACANT_ONES = '1;
endpackage

// File: rtl/uid_scan_controller.sv
// uid_scan_controller: scans an external synchronous user-ID ROM for a key
module uid_scan_controller
  import uid_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter logic [DATA_W-1:0] VACANT = VACANT_ONES[DATA_W-1:0],
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic mode,
  input logic [DATA_W-1:0] key,
  output logic [ADDR_W-1:0] rom_addr,
  input logic [DATA_W-1:0] rom_q,
  output logic busy,
  output logic done,
  output logic found,
  output logic [ADDR_W-1:0] match_idx,
  output logic [CNT_W-1:0] match_count
);
  scan_state_t state, state_nx;
  logic [DATA_W-1:0] key_q;
  logic mode_q;
  logic pend;
  logic [ADDR_W-1:0] cmp_idx;
  logic hit;
  logic last_addr;
  logic accept;
  assign accept = state == IDLE && start;
  assign last_addr = rom_addr == ADDR_W'(DEPTH - 1);
  assign hit = pend && (state == SCAN || state == DRAIN) && rom_q == key_q && rom_q != VACANT;
  assign busy = state == SCAN || state == DRAIN;
  assign done = state == FINISH;
  // next state: first-match abort wins over the end-of-table transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? SCAN : IDLE;
      SCAN: state_nx = hit && !mode_q ? FINISH : last_addr ? DRAIN : SCAN;
      DRAIN: state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // address counter, request latch and tracking of which entry rom_q belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      cmp_idx <= '0;
      pend <= 1'b0;
      key_q <= '0;
      mode_q <= 1'b0;
    end else begin
      pend <= state == SCAN;
      cmp_idx <= rom_addr;
      if (accept) begin
        rom_addr <= '0;
        key_q <= key;
        mode_q <= mode;
      end else if (state == SCAN && state_nx == SCAN) begin
        rom_addr <= rom_addr + 1'b1;
      end
    end
  end
  // compare/accumulate: results hold after done until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst || accept) begin
      found <= 1'b0;
      match_idx <= '0;
      match_count <= '0;
    end else if (hit) begin
      found <= 1'b1;
      match_idx <= found ? match_idx : cmp_idx;
      match_count <= match_count == CNT_W'(DEPTH) ? match_count : match_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_uid_scan_controller.sv
// tb_uid_scan_controller: randomized and directed checks against a scan-level model
module tb_uid_scan_controller;
  typedef struct packed {
    logic busy;
    logic done;
    logic found;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] addr;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, mode = 0;
  logic [15:0] key = 0;
  logic [15:0] rom [8] = '{16'h1234, 16'h0001, 16'h0002, 16'hBEEF, 16'h0004, 16'hFFFF, 16'hBEEF, 16'h0007};
  logic [2:0] a_addr, a_idx, b_addr, b_idx;
  logic [15:0] a_q, b_q;
  logic a_busy, a_done, a_found, b_busy, b_done, b_found;
  logic [3:0] a_cnt;
  logic [2:0] b_cnt;
  int total = 0, bad = 0;
  int ta = -1, tb = -1;
  logic [15:0] ka, kb;
  logic ma, mb;
  int da, db, mxa, mxb, nd, d1, d2;
  uid_scan_controller #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .rom_addr(a_addr), .rom_q(a_q),
    .busy(a_busy), .done(a_done), .found(a_found), .match_idx(a_idx), .match_count(a_cnt)
  );
  uid_scan_controller #(.DATA_W(16), .DEPTH(5), .ADDR_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .rom_addr(b_addr), .rom_q(b_q),
    .busy(b_busy), .done(b_done), .found(b_found), .match_idx(b_idx), .match_count(b_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    a_q <= rom[a_addr];
    b_q <= rom[b_addr];
  end
  function automatic exp_t expect_at(int depth, int t, logic [15:0] k, logic m);
    exp_t e;
    int hits[$];
    int end_t, amax, n;
    e = '0;
    if (t < 1) return e;
    for (int i = 0; i < depth; i++) if (rom[i] == k && k != 16'hFFFF) hits.push_back(i);
    while (!m && hits.size() > 1) void'(hits.pop_back());
    end_t = hits.size() > 0 && !m ? hits[0] + 3 : depth + 2;
    amax = hits.size() > 0 && !m ? (hits[0] + 1 < depth ? hits[0] + 1 : depth - 1) : depth - 1;
    n = 0;
    foreach (hits[i]) if (hits[i] + 3 <= t) n++;
    e.busy = t < end_t;
    e.done = t == end_t;
    e.addr = 3'(t - 1 < amax ? t - 1 : amax);
    e.found = n > 0;
    e.idx = n > 0 ? 3'(hits[0]) : 3'd0;
    e.cnt = 4'(n);
    return e;
  endfunction
  task automatic step(input int depth, inout int t, inout logic [15:0] k, inout logic m);
    exp_t e;
    e = expect_at(depth, t, k, m);
    if (e.busy || e.done) t++;
    else if (start) begin
      t = 1;
      k = key;
      m = mode;
    end
  endtask
  task automatic chk(string nm, logic [12:0] got, logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask
  task automatic lit(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      ta = -1;
      tb = -1;
    end else begin
      step(8, ta, ka, ma);
      step(5, tb, kb, mb);
    end
  always @(negedge clk) begin
    chk("model_a", {a_busy, a_done, a_found, a_idx, a_cnt, a_addr}, expect_at(8, ta, ka, ma));
    chk("model_b", {b_busy, b_done, b_found, b_idx, 1'b0, b_cnt, b_addr}, expect_at(5, tb, kb, mb));
  end
  task automatic scan(input logic [15:0] k, input logic m, input int pulse_at);
    key = k;
    mode = m;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    da = -1; db = -1; mxa = 0; mxb = 0; nd = 0;
    for (int c = 1; c <= 20; c++) begin
      start = c == pulse_at;
      key = 16'($urandom);
      mode = 1'($urandom);
      @(negedge clk);
      if (a_done) begin
        nd++;
        if (da < 0) da = c;
      end
      if (b_done && db < 0) db = c;
      if (int'(a_addr) > mxa) mxa = a_addr;
      if (int'(b_addr) > mxb) mxb = b_addr;
      @(posedge clk);
      #1;
    end
    start = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    lit("reset_a", {a_busy, a_done, a_found, a_idx, a_cnt, a_addr}, 0);
    lit("reset_b", {b_busy, b_done, b_found, b_idx, b_cnt, b_addr}, 0);
    scan(16'hBEEF, 1, -1);
    lit("full_done_t", da, 10);
    lit("full_found", a_found, 1);
    lit("full_idx", a_idx, 3);
    lit("full_cnt", a_cnt, 2);
    lit("full_b_done_t", db, 7);
    scan(16'hBEEF, 0, -1);
    lit("first_done_t", da, 6);
    lit("first_idx", a_idx, 3);
    lit("first_cnt", a_cnt, 1);
    lit("first_max_addr", mxa, 4);
    scan(16'hFFFF, 1, -1);
    lit("vacant_done_t", da, 10);
    lit("vacant_res", {a_found, a_idx, a_cnt}, 0);
    scan(16'h7777, 1, -1);
    lit("miss_done_t", da, 10);
    lit("miss_res", {a_found, a_idx, a_cnt}, 0);
    scan(16'h0004, 1, -1);
    lit("d5_done_t", db, 7);
    lit("d5_idx", b_idx, 4);
    lit("d5_cnt", b_cnt, 1);
    lit("d5_max_addr", mxb, 4);
    scan(16'hBEEF, 1, 4);
    lit("restart_ignored_dones", nd, 1);
    key = 16'hBEEF;
    mode = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #2 lit("pre_rst_busy", a_busy, 1);
    lit("pre_rst_addr", a_addr, 4);
    rst = 1;
    #1 lit("rst_async_a", {a_busy, a_done, a_found, a_idx, a_cnt, a_addr}, 0);
    lit("rst_async_b", {b_busy, b_done, b_found, b_idx, b_cnt, b_addr}, 0);
    @(posedge clk);
    #1 rst = 0;
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (a_done || b_done) nd++;
      @(posedge clk);
      #1;
    end
    lit("rst_no_done", nd, 0);
    scan(16'hBEEF, 1, -1);
    lit("post_rst_done_t", da, 10);
    lit("post_rst_cnt", a_cnt, 2);
    key = 16'hFFFF;
    mode = 1;
    start = 1;
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (a_done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      @(posedge clk);
      #1;
    end
    start = 0;
    lit("hold_start_gap", d2 - d1, 11);
    repeat (15) @(posedge clk);
    #1;
    for (int c = 0; c < 2500; c++) begin
      start = $urandom_range(0, 3) == 0;
      mode = 1'($urandom);
      case ($urandom_range(0, 4))
        0: key = 16'hBEEF;
        1: key = rom[$urandom_range(0, 7)];
        2: key = 16'hFFFF;
        3: key = 16'($urandom);
        default: key = 16'h0004;
      endcase
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1;
        #2 rst = 0;
      end
      @(posedge clk);
      #1;
    end
    start = 0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
